cv32e40s_instr_obi_arbiter: RTL and testbench
=============================================

# cv32e40s_instr_obi_arbiter

Shares the single instruction-side OBI transaction interface between two fetch requesters. Requester 0 is the prefetch unit's transaction port. Requester 1 is an auxiliary instruction-side fetcher, such as a pointer or re-fetch engine. The block arbitrates address-phase requests, holds the OBI address stable while a request is stalled, and caps the number of outstanding transactions. It records the requester ID of every issued transaction in an in-order FIFO and uses it to route each response back to its owner. Responses belonging to killed requester-0 transactions are dropped. The block sits between the prefetch unit and the OBI instruction interface.

## Interface
- MAX_OUTSTND, 2: maximum issued-but-unanswered transactions; must be ≥1.
- CNT_WIDTH, $clog2(MAX_OUTSTND+1): width of the outstanding count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req0_valid_i / req0_ready_o  in/out  1  requester 0 address handshake.
- req0_addr_i  in  32  requester 0 address.
- req1_valid_i / req1_ready_o  in/out  1  requester 1 address handshake.
- req1_addr_i  in  32  requester 1 address.
- kill0_i  in  1  discard all previously issued requester-0 transactions.
- trans_valid_o  out  1  OBI address-phase request.
- trans_ready_i  in  1  OBI address-phase grant.
- trans_addr_o  out  32  OBI address.
- resp_valid_i  in  1  OBI response valid.
- resp_i  in  inst_resp_t  OBI response payload.
- resp0_valid_o  out  1  response valid to requester 0.
- resp1_valid_o  out  1  response valid to requester 1.
- resp_o  out  inst_resp_t  response payload, broadcast to both requesters.
- outstnd_cnt_o  out  CNT_WIDTH  current outstanding count.
- busy_o  out  1  outstanding count ≠ 0.

## Operation
- **Requester rule:** once a requester raises reqN_valid_i, it keeps valid and address stable until reqN_ready_o.
- **Arbitration:** round-robin between the two requesters.
  - A `last_gnt` flop records the last issued requester.
  - When both requesters are valid, the one not equal to `last_gnt` wins.
  - If only one requester is valid, it wins.
- **Grant lock (OBI stability):** while trans_valid_o=1 and trans_ready_i=0, the `lock` flop holds the current winner.
  - Arbitration is frozen.
  - trans_addr_o stays constant until acceptance.
- **Issue condition:** trans_valid_o = winner valid AND count < MAX_OUTSTND.
  - A response arriving in the same cycle does not free a slot for that cycle.
- **Ready and count:**
  - reqN_ready_o = (winner==N) & trans_valid_o & trans_ready_i.
  - An issue pushes {id, discard=0} into the ID FIFO and increments the count.
- **Response routing:**
  - On resp_valid_i with the FIFO non-empty, pop the head entry.
  - If discard=0, assert resp{head.id}_valid_o for that cycle.
  - If discard=1, drop the response silently.
  - resp_o = resp_i at all times.
- **Kill:** kill0_i sets discard on every FIFO entry with id=0, including the entry being popped in the same cycle, which is therefore dropped.
  - A requester-0 issue in the kill cycle is pushed with discard=0 (for example, a branch target).
  - Requester-1 entries are unaffected.
- **Simultaneous issue and response:** push and pop in the same cycle; the count is unchanged.
- **Response with empty FIFO:** protocol error. Ignore it: no respN_valid_o, count stays 0.
- **Reset:**
  - FIFO is emptied, count=0, lock=0, last_gnt=1 (requester 0 wins first).
  - All valid/ready outputs are 0 and trans_addr_o=0.
  - Reset mid-transaction abandons all in-flight IDs.

## Timing
- Zero-latency combinational paths:
  - reqN_valid_i → trans_valid_o.
  - trans_ready_i → reqN_ready_o.
  - resp_valid_i → respN_valid_o.
- No combinational path from resp_valid_i to trans_valid_o.
- Sequential updates on the clk edge: FIFO, count, lock, last_gnt.
- last_gnt updates only on an accepted issue.
- lock = trans_valid_o & ~trans_ready_i, registered; it clears on the acceptance cycle.
- FIFO is a circular buffer of MAX_OUTSTND entries with wrap-around read/write pointers. Full is when count==MAX_OUTSTND, empty is when count==0.

## Structure
- Add to cv32e40s_pkg: typedef `obi_arb_entry_t` {logic id; logic discard;}. inst_resp_t is already shared there.
- Sub-module: cv32e40s_obi_id_fifo, holding the ID FIFO.
  - Push, pop, a kill-marking port, head and count outputs.
  - Parameterised by depth.
- Arbitration, lock and routing stay in the top module.

## Test plan
- **Alternation:** both requesters held valid with trans_ready_i=1, MAX_OUTSTND=2, one response every cycle → issues alternate 0,1,0,1 and responses route 0,1,0,1.
- **Address hold:** req1 wins while trans_ready_i=0 for 3 cycles, and req0 raises valid meanwhile → trans_addr_o holds req1_addr_i for all 3 cycles and req1 is granted first.
- **Outstanding cap:** req0 issues twice with no responses → trans_valid_o=0 and outstnd_cnt_o=2. A response arrives → trans_valid_o=1 on the next cycle.
- **Kill:** FIFO holds {0,1,0}, then kill0_i pulses → three responses produce only resp1_valid_o, on the second response.
- **Kill with simultaneous events:** kill0_i coincides with a req0 issue and a response for an old id0 entry → the old response is dropped, the new entry's response is delivered, and the count is unchanged in the kill cycle.
- **Reset and stray response:** rst asserted with 2 outstanding, then resp_valid_i=1 → no respN_valid_o, outstnd_cnt_o=0, and requester 0 wins the first arbitration.

Source files
------------

// File: rtl/cv32e40s_pkg.sv
// ============================================================================
// Module      : cv32e40s_pkg
// Description : Shared types for the instruction-side OBI path: the response
//               payload and the per-transaction bookkeeping entry used by the
//               instruction OBI arbiter's in-order ID FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40s_pkg;

    // OBI instruction response payload, passed unchanged to both requesters
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } inst_resp_t;

    // One in-flight transaction: which requester owns it, and whether its
    // response must be swallowed because the owner was killed meanwhile
    typedef struct packed {
        logic id;
        logic discard;
    } obi_arb_entry_t;

    localparam logic c_REQ0 = 1'b0;
    localparam logic c_REQ1 = 1'b1;

endpackage : cv32e40s_pkg

`default_nettype wire

// File: rtl/cv32e40s_obi_id_fifo.sv
// ============================================================================
// Module      : cv32e40s_obi_id_fifo
// Description : In-order circular FIFO of requester IDs for issued OBI
//               transactions. Pushes are ignored when full, pops when empty.
//               A kill marks every requester-0 entry as discard; the head
//               output already reflects a kill in the same cycle.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_push, i_push_id - record a newly issued transaction
//               i_pop             - retire the head entry
//               i_kill0           - mark all requester-0 entries discard
//               o_head            - current head entry
//               o_cnt             - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40s_obi_id_fifo
    import cv32e40s_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_push_id,
    input  logic                 i_pop,
    input  logic                 i_kill0,
    output obi_arb_entry_t       o_head,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);

    obi_arb_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign w_push = i_push & (r_cnt != CNT_WIDTH'(DEPTH));
    assign w_pop  = i_pop & (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Storage needs no reset: empty pointers make stale entries unreachable.
    // The push write comes last so an entry issued during a kill stays live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_kill0 && (r_mem[i].id == c_REQ0)) begin
                r_mem[i].discard <= 1'b1;
            end
        end
        if (w_push) begin
            r_mem[r_wptr] <= '{id: i_push_id, discard: 1'b0};
        end
    end

    assign o_head.id      = r_mem[r_rptr].id;
    assign o_head.discard = r_mem[r_rptr].discard
                          | (i_kill0 & (r_mem[r_rptr].id == c_REQ0));
    assign o_cnt          = r_cnt;

endmodule : cv32e40s_obi_id_fifo

`default_nettype wire

// File: rtl/cv32e40s_instr_obi_arbiter.sv
// ============================================================================
// Module      : cv32e40s_instr_obi_arbiter
// Description : Round-robin sharing of the instruction OBI interface between
//               the prefetcher (requester 0) and an auxiliary fetcher
//               (requester 1). Holds the granted address stable while
//               stalled, caps outstanding transactions, and routes responses
//               in order to their owner, dropping killed requester-0 ones.
// Ports       : clk, rst                      - clock, sync active-high reset
//               req0_*/req1_*                 - requester address handshakes
//               kill0_i                       - discard in-flight req0 traffic
//               trans_valid_o/ready_i/addr_o  - OBI address phase
//               resp_valid_i, resp_i          - OBI response phase
//               resp0_valid_o/resp1_valid_o   - routed response strobes
//               resp_o                        - response payload (broadcast)
//               outstnd_cnt_o, busy_o         - outstanding transaction state
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40s_instr_obi_arbiter
    import cv32e40s_pkg::*;
#(
    parameter int MAX_OUTSTND = 2,
    parameter int CNT_WIDTH   = $clog2(MAX_OUTSTND + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [31:0]          req0_addr_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [31:0]          req1_addr_i,
    input  logic                 kill0_i,
    output logic                 trans_valid_o,
    input  logic                 trans_ready_i,
    output logic [31:0]          trans_addr_o,
    input  logic                 resp_valid_i,
    input  inst_resp_t           resp_i,
    output logic                 resp0_valid_o,
    output logic                 resp1_valid_o,
    output inst_resp_t           resp_o,
    output logic [CNT_WIDTH-1:0] outstnd_cnt_o,
    output logic                 busy_o
);

    logic r_lock;
    logic r_lock_id;
    logic r_last_gnt;

    logic                 w_winner;
    logic                 w_winner_valid;
    logic                 w_slot_free;
    logic                 w_issue;
    logic                 w_stall;
    logic                 w_pop;
    obi_arb_entry_t       w_head;
    logic [CNT_WIDTH-1:0] w_cnt;

    // A stalled request keeps its grant so the OBI address cannot change
    always_comb begin
        w_winner = c_REQ0;
        if (r_lock) begin
            w_winner = r_lock_id;
        end else if (req0_valid_i && req1_valid_i) begin
            w_winner = ~r_last_gnt;
        end else if (req1_valid_i) begin
            w_winner = c_REQ1;
        end
    end

    assign w_winner_valid = (w_winner == c_REQ1) ? req1_valid_i : req0_valid_i;

    // Uses only the registered count, so a same-cycle response never frees a
    // slot and there is no path from resp_valid_i to trans_valid_o
    assign w_slot_free    = (w_cnt < CNT_WIDTH'(MAX_OUTSTND));

    assign trans_valid_o  = ~rst & w_winner_valid & w_slot_free;
    assign trans_addr_o   = (rst || !w_winner_valid) ? 32'h0 :
                            ((w_winner == c_REQ1) ? req1_addr_i : req0_addr_i);

    assign w_issue        = trans_valid_o & trans_ready_i;
    assign w_stall        = trans_valid_o & ~trans_ready_i;
    assign req0_ready_o   = w_issue & (w_winner == c_REQ0);
    assign req1_ready_o   = w_issue & (w_winner == c_REQ1);

    // A response with nothing outstanding is a protocol error and is ignored
    assign w_pop          = ~rst & resp_valid_i & (w_cnt != '0);
    assign resp0_valid_o  = w_pop & ~w_head.discard & (w_head.id == c_REQ0);
    assign resp1_valid_o  = w_pop & ~w_head.discard & (w_head.id == c_REQ1);
    assign resp_o         = resp_i;

    assign outstnd_cnt_o  = w_cnt;
    assign busy_o         = (w_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock     <= 1'b0;
            r_lock_id  <= c_REQ0;
            r_last_gnt <= c_REQ1;   // requester 0 wins the first contest
        end else begin
            r_lock    <= w_stall;
            r_lock_id <= w_winner;
            if (w_issue) begin
                r_last_gnt <= w_winner;
            end
        end
    end

    cv32e40s_obi_id_fifo #(
        .DEPTH     (MAX_OUTSTND),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_issue),
        .i_push_id (w_winner),
        .i_pop     (w_pop),
        .i_kill0   (kill0_i),
        .o_head    (w_head),
        .o_cnt     (w_cnt)
    );

endmodule : cv32e40s_instr_obi_arbiter

`default_nettype wire

// File: tb/tb_cv32e40s_instr_obi_arbiter.sv
// ============================================================================
// Module      : tb_cv32e40s_instr_obi_arbiter
// Description : Directed self-checking bench. u_dut uses two outstanding
//               slots; u_dut3 shares every input and uses three slots so a
//               three-entry ID history can be killed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40s_instr_obi_arbiter;
    import cv32e40s_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid_i, req1_valid_i;
    logic [31:0] req0_addr_i, req1_addr_i;
    logic        kill0_i, trans_ready_i, resp_valid_i;
    inst_resp_t  resp_i;

    logic        req0_ready_o, req1_ready_o, trans_valid_o;
    logic [31:0] trans_addr_o;
    logic        resp0_valid_o, resp1_valid_o, busy_o;
    inst_resp_t  resp_o;
    logic [1:0]  outstnd_cnt_o;

    logic        k_req0_ready, k_req1_ready, k_trans_valid;
    logic [31:0] k_trans_addr;
    logic        k_resp0_valid, k_resp1_valid, k_busy;
    inst_resp_t  k_resp;
    logic [1:0]  k_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    cv32e40s_instr_obi_arbiter #(.MAX_OUTSTND(2)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_addr_i(req0_addr_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_addr_i(req1_addr_i),
        .kill0_i(kill0_i),
        .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i), .trans_addr_o(trans_addr_o),
        .resp_valid_i(resp_valid_i), .resp_i(resp_i),
        .resp0_valid_o(resp0_valid_o), .resp1_valid_o(resp1_valid_o), .resp_o(resp_o),
        .outstnd_cnt_o(outstnd_cnt_o), .busy_o(busy_o)
    );

    cv32e40s_instr_obi_arbiter #(.MAX_OUTSTND(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_ready_o(k_req0_ready), .req0_addr_i(req0_addr_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(k_req1_ready), .req1_addr_i(req1_addr_i),
        .kill0_i(kill0_i),
        .trans_valid_o(k_trans_valid), .trans_ready_i(trans_ready_i), .trans_addr_o(k_trans_addr),
        .resp_valid_i(resp_valid_i), .resp_i(resp_i),
        .resp0_valid_o(k_resp0_valid), .resp1_valid_o(k_resp1_valid), .resp_o(k_resp),
        .outstnd_cnt_o(k_cnt), .busy_o(k_busy)
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge; checks follow #1 later
    task automatic drive(input logic r,
                         input logic v0, input logic [31:0] a0,
                         input logic v1, input logic [31:0] a1,
                         input logic tr, input logic rv, input logic k);
        @(negedge clk);
        cyc++;
        rst           = r;
        req0_valid_i  = v0;
        req0_addr_i   = a0;
        req1_valid_i  = v1;
        req1_addr_i   = a1;
        trans_ready_i = tr;
        resp_valid_i  = rv;
        kill0_i       = k;
        resp_i        = '{rdata: 32'hD000_0000 ^ cyc, err: cyc[0]};
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid_i = 0; req1_valid_i = 0; req0_addr_i = 0; req1_addr_i = 0;
        kill0_i = 0; trans_ready_i = 0; resp_valid_i = 0; resp_i = '0;

        // Reset state: outputs forced quiet even with active inputs
        drive(1, 1, 32'h11, 1, 32'h22, 1, 1, 0);
        drive(1, 1, 32'h11, 1, 32'h22, 1, 1, 0);
        chk("rst_tvalid", trans_valid_o, 0);
        chk("rst_taddr",  trans_addr_o, 0);
        chk("rst_rdy0",   req0_ready_o, 0);
        chk("rst_resp0",  resp0_valid_o, 0);
        chk("rst_resp1",  resp1_valid_o, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_cnt",  outstnd_cnt_o, 0);
        chk("rst_busy", busy_o, 0);

        // Alternation: issue owner i%2, response in cycle i belongs to issue i-1
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h1000 + i, 1, 32'h2000 + i, 1, (i > 0), 0);
            chk("alt_addr",  trans_addr_o, i[0] ? 32'h2000 + i : 32'h1000 + i);
            chk("alt_rdy0",  req0_ready_o, !i[0]);
            chk("alt_rdy1",  req1_ready_o, i[0]);
            chk("alt_resp0", resp0_valid_o, (i > 0) && i[0]);
            chk("alt_resp1", resp1_valid_o, (i > 0) && !i[0]);
            chk("alt_cnt",   outstnd_cnt_o, (i > 0) ? 1 : 0);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("alt_last_resp1", resp1_valid_o, 1);
        chk("alt_resp_o",     resp_o, resp_i);

        // Address hold: req1 stalled 3 cycles, req0 arrives meanwhile
        drive(0, 0, 0, 1, 32'h300, 0, 0, 0);
        chk("hold_cnt0",   outstnd_cnt_o, 0);
        chk("hold_tvalid", trans_valid_o, 1);
        chk("hold_addr1",  trans_addr_o, 32'h300);
        chk("hold_rdy1a",  req1_ready_o, 0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 32'h400, 1, 32'h300, 0, 0, 0);
            chk("hold_addr", trans_addr_o, 32'h300);
            chk("hold_rdy0", req0_ready_o, 0);
        end
        drive(0, 1, 32'h400, 1, 32'h300, 1, 0, 0);
        chk("hold_gnt_addr", trans_addr_o, 32'h300);
        chk("hold_gnt_rdy1", req1_ready_o, 1);
        chk("hold_gnt_rdy0", req0_ready_o, 0);
        drive(0, 1, 32'h400, 0, 0, 1, 0, 0);
        chk("hold_next_addr", trans_addr_o, 32'h400);
        chk("hold_next_rdy0", req0_ready_o, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("hold_drain_r1", resp1_valid_o, 1);
        chk("hold_drain_r0", resp0_valid_o, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("hold_drain_r0b", resp0_valid_o, 1);
        chk("hold_drain_cnt", outstnd_cnt_o, 1);

        // Outstanding cap with two slots
        drive(0, 1, 32'h500, 0, 0, 1, 0, 0);
        chk("cap_rdy0_a", req0_ready_o, 1);
        drive(0, 1, 32'h504, 0, 0, 1, 0, 0);
        chk("cap_rdy0_b", req0_ready_o, 1);
        drive(0, 1, 32'h508, 0, 0, 1, 1, 0);
        chk("cap_tvalid_full", trans_valid_o, 0);
        chk("cap_cnt_full",    outstnd_cnt_o, 2);
        chk("cap_busy",        busy_o, 1);
        chk("cap_rdy0_full",   req0_ready_o, 0);
        chk("cap_resp0",       resp0_valid_o, 1);
        drive(0, 1, 32'h508, 0, 0, 1, 0, 0);
        chk("cap_tvalid_free", trans_valid_o, 1);
        chk("cap_cnt_free",    outstnd_cnt_o, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("cap_drain_a", resp0_valid_o, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("cap_drain_b", resp0_valid_o, 1);

        // Reset with two outstanding, then a stray response
        drive(0, 1, 32'h600, 0, 0, 1, 0, 0);
        drive(0, 1, 32'h604, 0, 0, 1, 0, 0);
        chk("rr_cnt_pre", outstnd_cnt_o, 1);
        drive(1, 1, 32'h608, 1, 32'h708, 1, 1, 0);
        chk("rr_tvalid", trans_valid_o, 0);
        chk("rr_taddr",  trans_addr_o, 0);
        chk("rr_resp0",  resp0_valid_o, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("stray_resp0", resp0_valid_o, 0);
        chk("stray_resp1", resp1_valid_o, 0);
        chk("stray_cnt",   outstnd_cnt_o, 0);
        drive(0, 1, 32'h610, 1, 32'h710, 1, 0, 0);
        chk("stray_cnt_after", outstnd_cnt_o, 0);
        chk("rr_first_addr",   trans_addr_o, 32'h610);
        chk("rr_first_rdy0",   req0_ready_o, 1);
        chk("rr_first_rdy1",   req1_ready_o, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("rr_drain", resp0_valid_o, 1);

        // Kill over a {0,1,0} history on the three-slot instance
        drive(0, 1, 32'h800, 0, 0, 1, 0, 0);
        chk("kill_iss0", k_req0_ready, 1);
        drive(0, 0, 0, 1, 32'h900, 1, 0, 0);
        chk("kill_iss1", k_req1_ready, 1);
        drive(0, 1, 32'h804, 0, 0, 1, 0, 0);
        chk("kill_iss2", k_req0_ready, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("kill_cnt3", k_cnt, 3);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("kill_r1_0", k_resp0_valid, 0);
        chk("kill_r1_1", k_resp1_valid, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("kill_r2_0", k_resp0_valid, 0);
        chk("kill_r2_1", k_resp1_valid, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("kill_r3_0", k_resp0_valid, 0);
        chk("kill_r3_1", k_resp1_valid, 0);
        chk("kill_r3_cnt", k_cnt, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("kill_cnt_end", k_cnt, 0);
        chk("kill_cnt_end2", outstnd_cnt_o, 0);

        // Kill coinciding with a new req0 issue and an old req0 response
        drive(0, 1, 32'hA00, 0, 0, 1, 0, 0);
        chk("ks_iss_old", req0_ready_o, 1);
        drive(0, 1, 32'hA04, 0, 0, 1, 1, 1);
        chk("ks_iss_new", req0_ready_o, 1);
        chk("ks_drop0",   resp0_valid_o, 0);
        chk("ks_drop1",   resp1_valid_o, 0);
        chk("ks_cnt_pre", outstnd_cnt_o, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("ks_cnt_same", outstnd_cnt_o, 1);
        chk("ks_new_resp", resp0_valid_o, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ks_cnt_end", outstnd_cnt_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_cv32e40s_instr_obi_arbiter

`default_nettype wire
